// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch sequencer.
package fetch_pkg;

  localparam int unsigned PC_W         = 32;
  localparam int unsigned INSTR_W      = 32;
  localparam int unsigned DEF_ADDR_W   = 9;
  localparam logic [PC_W-1:0] DEF_RESET_PC = 32'h0000_0000;
  localparam int unsigned PC_STEP      = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

  // Instructions are word aligned; the low two byte-address bits are dropped.
  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] pc);
    return pc & ~PC_W'(3);
  endfunction

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Fetch bus: instr_mem read port plus the valid/ready channel into decode.
interface instr_fetch_ctrl_if
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = INSTR_W
) ();

  logic              imem_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_data;
  logic              if_valid;
  logic              if_ready;
  logic [DATA_W-1:0] if_instr;
  logic [PC_W-1:0]   if_pc;

  modport master (
    output imem_en, imem_addr, if_valid, if_instr, if_pc,
    input  imem_data, if_ready
  );

  modport slave (
    input  imem_en, imem_addr, if_valid, if_instr, if_pc,
    output imem_data, if_ready
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a fetched {instr, pc} pair.
module fetch_skid_buf
  import fetch_pkg::*;
#(
  parameter int unsigned DATA_W = INSTR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              flush,
  input  logic              drain,
  input  logic [DATA_W-1:0] load_instr,
  input  logic [PC_W-1:0]   load_pc,
  output logic              valid,
  output logic [DATA_W-1:0] instr,
  output logic [PC_W-1:0]   pc
);

  // Flush wins over load so a redirect never leaves a wrong-path word behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= load_instr;
      pc    <= load_pc;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues instr_mem reads, absorbs read latency
// and decode backpressure with a skid entry, and applies redirects.
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned     ADDR_W   = DEF_ADDR_W,
  parameter logic [PC_W-1:0] RESET_PC = DEF_RESET_PC,
  parameter int unsigned     DATA_W   = INSTR_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            halt,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            busy,
  instr_fetch_ctrl_if.master bus
);

  localparam logic [0:0] IDLE = ST_IDLE;
  localparam logic [0:0] RUN  = ST_RUN;

  logic [0:0]        state, state_nxt;
  logic [PC_W-1:0]   fetch_pc, fetch_pc_nxt;
  logic [PC_W-1:0]   pend_pc, pend_pc_nxt;
  logic              pend, pend_nxt;
  logic [PC_W-1:0]   target;
  logic              run, redir, pend_show, issue;
  logic              imem_en_c;
  logic [ADDR_W-1:0] imem_addr_c;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_instr;
  logic [PC_W-1:0]   skid_pc;

  assign run       = (state == RUN);
  assign redir     = run & redirect_valid;
  assign target    = word_align(redirect_pc);
  assign pend_show = pend & ~redir;
  assign issue     = run & ~halt & ~skid_valid & (~pend | bus.if_ready);

  // Next state, PC sequencing and memory request.
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    pend_nxt     = 1'b0;
    pend_pc_nxt  = pend_pc;
    imem_en_c    = 1'b0;
    imem_addr_c  = fetch_pc[ADDR_W+1:2];

    case (state)
      IDLE:    if (start && !halt) state_nxt = RUN;
      RUN:     if (halt)           state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase

    if (redir) begin
      if (halt) begin
        fetch_pc_nxt = target;
      end else begin
        imem_en_c    = 1'b1;
        imem_addr_c  = target[ADDR_W+1:2];
        pend_nxt     = 1'b1;
        pend_pc_nxt  = target;
        fetch_pc_nxt = target + PC_W'(PC_STEP);
      end
    end else if (issue) begin
      imem_en_c    = 1'b1;
      pend_nxt     = 1'b1;
      pend_pc_nxt  = fetch_pc;
      fetch_pc_nxt = fetch_pc + PC_W'(PC_STEP);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      pend     <= 1'b0;
      pend_pc  <= '0;
    end else begin
      fetch_pc <= fetch_pc_nxt;
      pend     <= pend_nxt;
      pend_pc  <= pend_pc_nxt;
    end
  end

  // A returning word that decode cannot take is parked until it can.
  fetch_skid_buf #(.DATA_W(DATA_W)) u_skid (
    .clk        (clk),
    .rst        (rst),
    .load       (pend & ~bus.if_ready & ~redir),
    .flush      (redir),
    .drain      (skid_valid & bus.if_ready),
    .load_instr (bus.imem_data),
    .load_pc    (pend_pc),
    .valid      (skid_valid),
    .instr      (skid_instr),
    .pc         (skid_pc)
  );

  assign bus.imem_en   = imem_en_c;
  assign bus.imem_addr = imem_addr_c;
  assign bus.if_valid  = skid_valid | pend_show;
  assign bus.if_instr  = skid_valid ? skid_instr : (pend_show ? bus.imem_data : '0);
  assign bus.if_pc     = skid_valid ? skid_pc    : (pend_show ? pend_pc       : '0);
  assign busy          = run | pend | skid_valid;

endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
Fetch sequencer for the synchronous instruction memory (instr_mem).
- Owns the PC and drives instr_en/addr.
- Absorbs the memory's 1-cycle read latency and handles downstream backpressure with a 1-entry skid buffer.
- Applies branch/jump redirects.
- Sits between instr_mem and the decode stage; its valid/ready output feeds decode.

Parameters:
ADDR_W, 9, word-address width of instr_mem (memory size 2^ADDR_W words)
RESET_PC, 32'h0000_0000, byte PC loaded at reset
DATA_W, 32, instruction width

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  IDLE->RUN, begin fetching from current fetch_pc
halt  in  1  RUN->IDLE, stop issuing; in-flight word still delivered
redirect_valid  in  1  taken branch/jump this cycle
redirect_pc  in  32  byte target; bits [1:0] ignored (forced 0)
imem_en  out  1  to instr_mem instr_en
imem_addr  out  ADDR_W  to instr_mem addr = issued_pc[ADDR_W+1:2]
imem_data  in  DATA_W  from instr_mem instr_out, valid 1 cycle after imem_en
if_valid  out  1  instruction available to decode
if_ready  in  1  decode accepts (transfer when if_valid & if_ready)
if_instr  out  DATA_W  instruction; 0 when if_valid=0
if_pc  out  32  byte PC of if_instr; 0 when if_valid=0
busy  out  1  state==RUN or pend or skid_valid

Behaviour:
- State: fetch_pc[31:0], FSM {IDLE, RUN}, pend (read issued last cycle), pend_pc, skid_valid/skid_instr/skid_pc.
- Reset (async, immediate): state=IDLE, fetch_pc=RESET_PC, pend=0, skid_valid=0, skid_instr=0, skid_pc=0.
  - All outputs 0: imem_en=0, imem_addr=RESET_PC[ADDR_W+1:2], if_valid=0, busy=0.
- FSM transitions:
  - IDLE->RUN on start.
  - RUN->IDLE on halt; halt has priority over start.
  - start in RUN and halt in IDLE have no effect.
- Output mux:
  - if_valid = skid_valid | (pend & ~redirect_valid).
  - Source is the skid entry if skid_valid, else imem_data/pend_pc.
- Normal issue: issue = RUN & ~halt & ~skid_valid & (~pend | if_ready).
  - On issue: imem_en=1, imem_addr=fetch_pc[ADDR_W+1:2], pend<=1, pend_pc<=fetch_pc, fetch_pc<=fetch_pc+4.
  - Otherwise: imem_en=0, pend<=0.
- Latency and throughput:
  - First if_valid 2 cycles after start is sampled.
  - 1 instr/cycle while if_ready=1.
- Backpressure:
  - pend & ~if_ready & ~redirect_valid: capture imem_data/pend_pc into skid (skid_valid<=1); no issue.
  - skid_valid & if_ready: skid drains. Issue resumes the following cycle, so there is exactly one bubble after stall release.
  - No instruction is dropped or duplicated. if_instr/if_pc are stable while if_valid & ~if_ready.
- Redirect (RUN only; ignored in IDLE):
  - Same cycle: skid_valid<=0, pend output suppressed (if_valid=0).
  - Same cycle, if ~halt: imem_en=1, imem_addr=target[ADDR_W+1:2], pend<=1, pend_pc<=target, fetch_pc<=target+4.
  - The target instruction is valid next cycle.
  - Redirect overrides skid-full and if_ready=0.
  - redirect & halt: fetch_pc<=target, no issue, go IDLE.
- Wrap-around:
  - fetch_pc increments modulo 2^32.
  - imem_addr wraps naturally (word 2^ADDR_W-1 -> 0); if_pc keeps the full 32-bit value.
- halt mid-stream: an outstanding pend or skid word is still presented and must be accepted before busy drops.

Decomposition:
- Package fetch_pkg:
  - FSM state enum {IDLE, RUN}.
  - Constants PC_W=32, INSTR_W=32, default ADDR_W=9, default RESET_PC, PC_STEP=4.
- One sub-module: fetch_skid_buf, a 1-entry holding register with load/flush/drain and valid flag, holding {instr, pc}.
- The PC/FSM/issue logic stays in instr_fetch_ctrl.

Test Plan:
- Preload word i = 32'hA000_0000+i. Reset, start, if_ready=1 -> if_valid 2 cycles after start; if_pc 0,4,8,...; if_instr A0000000,A0000001,... one per cycle.
- if_ready=0 for 3 cycles while if_pc=0x10 -> if_instr=A0000004/if_pc=0x10 held stable, imem_en=0. After release: 0x10 accepted, one bubble, then 0x14 with no loss or duplicate.
- redirect_valid with redirect_pc=0x43 while pend=1 -> if_valid=0 that cycle, imem_addr=0x10; next cycle if_pc=0x40, if_instr=A0000010.
- Redirect to 0x7FC -> if_pc 0x7FC (word 511), then 0x800 with imem_addr=0 and if_instr=A0000000.
- Skid full plus if_ready=0 plus redirect to 0x20 in the same cycle -> skid flushed, next valid if_pc=0x20.
- Assert rst mid-stream (not on a clock edge) -> imem_en, if_valid, busy drop to 0 immediately. After release: IDLE, no fetch until start, then restart at RESET_PC.
